unique_perm_gen: RTL and testbench

UNIQUE_PERM_GEN -- requirements
Module: unique_perm_gen

---
 rtl/unique_perm_gen.sv | 100 ++++++++++
 tb/tb_unique_perm_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unique_perm_gen.sv
// Collects unique candidate values into a first-arrival permutation table.
// A RANGE-bit occupancy bitmap is used to reject duplicates; the table is read back through a registered port.
module unique_perm_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RANGE  = 2 ** DATA_W,
  parameter int unsigned DEPTH  = RANGE,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              new_pulse,
  output logic              dup_pulse,
  output logic              oor_pulse,
  output logic [CNT_W-1:0]  count,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned BIT_W = $clog2(RANGE);

  logic [RANGE-1:0]  bitmap;
  logic [DATA_W-1:0] table_mem [DEPTH];
  logic              in_range;
  logic [BIT_W-1:0]  bit_idx;
  logic              accept;
  logic              is_dup;
  logic              store;

  // Range check folds to a constant when every code of in_data is legal.
  generate
    if (RANGE < 2 ** DATA_W) begin : g_range_cmp
      assign in_range = ({1'b0, in_data} < (DATA_W + 1)'(RANGE));
    end else begin : g_range_full
      assign in_range = 1'b1;
    end
  endgenerate

  // Reset forces ready high so the block looks idle while held in reset.
  assign in_ready = !done || !rst;

  always_comb begin
    bit_idx = '0;
    accept  = 1'b0;
    is_dup  = 1'b0;
    store   = 1'b0;
    if (in_range) begin
      bit_idx = BIT_W'(in_data);
    end
    accept = rst && in_valid && in_ready && !clear;
    is_dup = bitmap[bit_idx];
    store  = accept && in_range && !is_dup;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bitmap    <= '0;
      count     <= '0;
      done      <= 1'b0;
      new_pulse <= 1'b0;
      dup_pulse <= 1'b0;
      oor_pulse <= 1'b0;
      rd_data   <= '0;
    end else begin
      new_pulse <= 1'b0;
      dup_pulse <= 1'b0;
      oor_pulse <= 1'b0;
      rd_data   <= table_mem[rd_addr];
      if (clear) begin
        bitmap <= '0;
        count  <= '0;
        done   <= 1'b0;
      end else if (accept) begin
        if (!in_range) begin
          oor_pulse <= 1'b1;
        end else if (is_dup) begin
          dup_pulse <= 1'b1;
        end else begin
          bitmap[bit_idx] <= 1'b1;
          count           <= count + CNT_W'(1);
          done            <= (count == CNT_W'(DEPTH - 1));
          new_pulse       <= 1'b1;
        end
      end
    end
  end

  // Table has no reset so it can map onto a plain RAM; clear leaves it intact.
  always_ff @(posedge clk) begin
    if (store) begin
      table_mem[ADDR_W'(count)] <= in_data;
    end
  end

endmodule

// File: tb/tb_unique_perm_gen.sv
// Directed bench for unique_perm_gen: three instances cover the default,
// reduced-RANGE and 4-bit configurations.
module tb_unique_perm_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Instance a: DATA_W=8, RANGE=DEPTH=256
  logic       a_clear = 0, a_valid = 0, a_ready, a_new, a_dup, a_oor, a_done;
  logic [7:0] a_data = 0, a_rd_addr = 0, a_rd_data;
  logic [8:0] a_count;
  unique_perm_gen #(.DATA_W(8)) u_a (
    .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .new_pulse(a_new), .dup_pulse(a_dup), .oor_pulse(a_oor),
    .count(a_count), .done(a_done), .rd_addr(a_rd_addr), .rd_data(a_rd_data));

  // Instance b: RANGE=DEPTH=200
  logic       b_clear = 0, b_valid = 0, b_ready, b_new, b_dup, b_oor, b_done;
  logic [7:0] b_data = 0, b_rd_addr = 0, b_rd_data;
  logic [7:0] b_count;
  unique_perm_gen #(.DATA_W(8), .RANGE(200), .DEPTH(200)) u_b (
    .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .new_pulse(b_new), .dup_pulse(b_dup), .oor_pulse(b_oor),
    .count(b_count), .done(b_done), .rd_addr(b_rd_addr), .rd_data(b_rd_data));

  // Instance c: DATA_W=4, RANGE=DEPTH=16
  logic       c_clear = 0, c_valid = 0, c_ready, c_new, c_dup, c_oor, c_done;
  logic [3:0] c_data = 0, c_rd_addr = 0, c_rd_data;
  logic [4:0] c_count;
  unique_perm_gen #(.DATA_W(4)) u_c (
    .clk(clk), .rst(rst), .clear(c_clear), .in_valid(c_valid), .in_data(c_data),
    .in_ready(c_ready), .new_pulse(c_new), .dup_pulse(c_dup), .oor_pulse(c_oor),
    .count(c_count), .done(c_done), .rd_addr(c_rd_addr), .rd_data(c_rd_data));

  task automatic a_feed(input logic [7:0] d);
    a_valid = 1'b1;
    a_data  = d;
    @(posedge clk); #1;
  endtask

  task automatic a_clear_all();
    a_valid = 1'b0;
    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; a_valid = 1'b1; a_data = 8'h10;
    @(posedge clk); #1;
    checks++;
    if (a_count !== 9'd0 || a_done !== 1'b0) begin
      errors++; $display("FAIL reset_count count=%0d done=%b want 0/0", a_count, a_done);
    end
    checks++;
    if ({a_new, a_dup, a_oor} !== 3'b000 || a_rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_outs pulses=%b rd_data=%h want 000/00", {a_new, a_dup, a_oor}, a_rd_data);
    end
    checks++;
    if (a_ready !== 1'b1 || c_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready a=%b c=%b want 1", a_ready, c_ready);
    end
    a_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_dup();
    logic [7:0] vals [3];
    logic [2:0] exp [3];
    logic [7:0] tbl [2];
    vals = '{8'h3A, 8'h3A, 8'h7F};
    exp  = '{3'b100, 3'b010, 3'b100};
    tbl  = '{8'h3A, 8'h7F};
    for (int i = 0; i < 3; i++) begin
      a_feed(vals[i]);
      checks++;
      if ({a_new, a_dup, a_oor} !== exp[i]) begin
        errors++; $display("FAIL dup_pulse[%0d] got=%b want=%b", i, {a_new, a_dup, a_oor}, exp[i]);
      end
    end
    a_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({a_new, a_dup, a_oor} !== 3'b000 || a_count !== 9'd2) begin
      errors++; $display("FAIL dup_idle pulses=%b count=%0d want 000/2", {a_new, a_dup, a_oor}, a_count);
    end
    for (int i = 0; i < 2; i++) begin
      a_rd_addr = 8'(i);
      @(posedge clk); #1;
      checks++;
      if (a_rd_data !== tbl[i]) begin
        errors++; $display("FAIL dup_table[%0d] got=%h want=%h", i, a_rd_data, tbl[i]);
      end
    end
  endtask

  task automatic test_clear_priority();
    a_clear_all();
    for (int i = 1; i <= 5; i++) a_feed(8'(i));
    checks++;
    if (a_count !== 9'd5) begin
      errors++; $display("FAIL clear_pre count=%0d want 5", a_count);
    end
    a_clear = 1'b1; a_valid = 1'b1; a_data = 8'h11;
    @(posedge clk); #1;
    a_clear = 1'b0;
    checks++;
    if (a_count !== 9'd0 || {a_new, a_dup, a_oor} !== 3'b000) begin
      errors++; $display("FAIL clear_drop count=%0d pulses=%b want 0/000", a_count, {a_new, a_dup, a_oor});
    end
    a_feed(8'h11);
    checks++;
    if ({a_new, a_dup, a_oor} !== 3'b100) begin
      errors++; $display("FAIL clear_refeed pulses=%b want 100", {a_new, a_dup, a_oor});
    end
    a_feed(8'h03);
    checks++;
    if ({a_new, a_dup, a_oor} !== 3'b100 || a_count !== 9'd2) begin
      errors++; $display("FAIL clear_old_new pulses=%b count=%0d want 100/2", {a_new, a_dup, a_oor}, a_count);
    end
    a_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_clear_all();
    for (int i = 0; i < 9; i++) a_feed(8'h20 + 8'(i));
    checks++;
    if (a_count !== 9'd9) begin
      errors++; $display("FAIL rstmid_pre count=%0d want 9", a_count);
    end
    rst = 1'b0; a_valid = 1'b1; a_data = 8'h30;
    @(posedge clk); #1;
    checks++;
    if (a_count !== 9'd0 || a_done !== 1'b0 || {a_new, a_dup, a_oor} !== 3'b000 || a_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_state count=%0d done=%b pulses=%b ready=%b want 0/0/000/1",
                         a_count, a_done, {a_new, a_dup, a_oor}, a_ready);
    end
    rst = 1'b1;
    a_feed(8'h40);
    a_valid = 1'b0;
    a_rd_addr = 8'd0;
    @(posedge clk); #1;
    checks++;
    if (a_rd_data !== 8'h40 || a_count !== 9'd1) begin
      errors++; $display("FAIL rstmid_first rd_data=%h count=%0d want 40/1", a_rd_data, a_count);
    end
  endtask

  task automatic test_read_before_write();
    a_clear_all();
    for (int i = 0; i < 4; i++) a_feed(8'h96 + 8'(i));
    a_clear_all();
    for (int i = 0; i < 3; i++) a_feed(8'h70 + 8'(i));
    a_valid = 1'b0;
    a_rd_addr = 8'd3;
    a_feed(8'h55);
    checks++;
    if (a_rd_data !== 8'h99 || a_new !== 1'b1) begin
      errors++; $display("FAIL rbw_old rd_data=%h new=%b want 99/1", a_rd_data, a_new);
    end
    a_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a_rd_data !== 8'h55) begin
      errors++; $display("FAIL rbw_new rd_data=%h want 55", a_rd_data);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] vals [3];
    logic [2:0] exp [3];
    vals = '{8'hC8, 8'hC7, 8'hFF};
    exp  = '{3'b001, 3'b100, 3'b001};
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1; b_data = vals[i];
      @(posedge clk); #1;
      checks++;
      if ({b_new, b_dup, b_oor} !== exp[i]) begin
        errors++; $display("FAIL oor_pulse[%0d] got=%b want=%b", i, {b_new, b_dup, b_oor}, exp[i]);
      end
    end
    b_valid = 1'b0; b_rd_addr = 8'd0;
    @(posedge clk); #1;
    checks++;
    if (b_count !== 8'd1 || b_rd_data !== 8'hC7) begin
      errors++; $display("FAIL oor_state count=%0d rd_data=%h want 1/c7", b_count, b_rd_data);
    end
  endtask

  task automatic test_full_collection();
    int unsigned stream [64] = '{
      3, 3, 9, 0, 14, 9, 5, 1, 1, 12, 7, 3, 15, 0, 10, 6,
      2, 2, 11, 8, 5, 13, 4, 14, 9, 0, 1, 2, 3, 7, 7, 6,
      15, 15, 10, 4, 12, 8, 11, 13, 5, 9, 0, 3, 14, 1, 2, 6,
      7, 4, 8, 10, 12, 11, 13, 15, 0, 5, 9, 3, 1, 14, 2, 6};
    logic [15:0] seen = '0;
    logic [3:0]  order [16];
    int unsigned n = 0;
    logic        mdone = 1'b0;
    logic [2:0]  exp;
    for (int i = 0; i < 64; i++) begin
      c_valid = 1'b1; c_data = 4'(stream[i]);
      @(posedge clk); #1;
      exp = 3'b000;
      if (!mdone) begin
        if (seen[stream[i]]) exp = 3'b010;
        else begin
          exp = 3'b100; seen[stream[i]] = 1'b1; order[n] = 4'(stream[i]); n++;
          if (n == 16) mdone = 1'b1;
        end
      end
      checks++;
      if ({c_new, c_dup, c_oor} !== exp || c_count !== 5'(n) || c_done !== mdone || c_ready !== !mdone) begin
        errors++; $display("FAIL full[%0d] pulses=%b count=%0d done=%b ready=%b want %b/%0d/%b/%b",
                           i, {c_new, c_dup, c_oor}, c_count, c_done, c_ready, exp, n, mdone, !mdone);
      end
    end
    c_valid = 1'b0;
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      c_rd_addr = 4'(i);
      @(posedge clk); #1;
      seen[c_rd_data] = 1'b1;
      checks++;
      if (c_rd_data !== order[i]) begin
        errors++; $display("FAIL full_table[%0d] got=%0d want=%0d", i, c_rd_data, order[i]);
      end
    end
    checks++;
    if (seen !== 16'hFFFF) begin
      errors++; $display("FAIL full_perm coverage=%h want ffff", seen);
    end
  endtask

  initial begin
    test_reset();
    test_dup();
    test_clear_priority();
    test_reset_mid();
    test_read_before_write();
    test_out_of_range();
    test_full_collection();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
